// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for the pipelined MIPS core.
// A registered scoreboard records the destination register of every in-flight
// post-ID instruction (entry 0 = EX ... entry DEPTH-1 = WB). Latch enables,
// flushes, the PC enable and the forwarding selects are derived combinationally
// from the scoreboard and the current ID/MEM inputs.
module hazard_scoreboard #(
    parameter int DEPTH          = 3,
    parameter int FWD_EN         = 1,
    parameter int REDIRECT_STAGE = 1,
    parameter int FS             = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          id_valid,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr,
    input  logic [4:0]    id_wsel,
    input  logic          id_late,
    input  logic          redirect,
    input  logic          dmem_req,
    input  logic          dhit,
    output logic          pc_en,
    output logic          en_ID,
    output logic          en_EX,
    output logic          en_MEM,
    output logic          flush_ID,
    output logic          flush_EX,
    output logic          flush_MEM,
    output logic [FS-1:0] fwd_rs,
    output logic [FS-1:0] fwd_rt,
    output logic [1:0]    hazard,
    output logic [15:0]   stall_cnt
);

    typedef enum logic [1:0] {
        HZ_NONE = 2'd0,
        HZ_CTRL = 2'd1,
        HZ_DATA = 2'd2,
        HZ_MEM  = 2'd3
    } hz_e;

    // Scoreboard state: valid bits are control, wsel/late ride along as data.
    logic [DEPTH-1:0] sb_v;
    logic [DEPTH-1:0] sb_late;
    logic [4:0]       sb_wsel [DEPTH];
    logic [DEPTH-1:0] nxt_v;
    logic [DEPTH-1:0] nxt_late;
    logic [4:0]       nxt_wsel [DEPTH];

    logic [DEPTH-1:0] hit_rs;
    logic [DEPTH-1:0] hit_rt;
    logic             stall_hit;
    hz_e              hz;

    // Select of the youngest (lowest-index) matching entry, encoded as index+1.
    function automatic logic [FS-1:0] youngest(input logic [DEPTH-1:0] hits);
        logic [FS-1:0] sel;
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hits[i]) sel = FS'(i + 1);
        end
        return sel;
    endfunction

    // Saturating 16-bit increment for the stall counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Per-entry match against the used ID sources; register 0 never matches.
    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_rs[i] = sb_v[i] && (sb_wsel[i] != 5'd0) && id_use_rs && (sb_wsel[i] == id_rs);
            hit_rt[i] = sb_v[i] && (sb_wsel[i] != 5'd0) && id_use_rt && (sb_wsel[i] == id_rt);
        end
    end

    // Data hazard: with forwarding only a late result in EX stalls; without it,
    // every entry before WB stalls (WB is covered by register-file write-through).
    always_comb begin
        stall_hit = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if ((FWD_EN == 0) || ((i == 0) && sb_late[0])) begin
                stall_hit = stall_hit | hit_rs[i] | hit_rt[i];
            end
        end
        stall_hit = id_valid && stall_hit;
    end

    // Hazard priority: memory freeze, then redirect, then data stall.
    always_comb begin
        hz = HZ_NONE;
        if (dmem_req && !dhit) begin
            hz = HZ_MEM;
        end else if (redirect) begin
            hz = HZ_CTRL;
        end else if (stall_hit) begin
            hz = HZ_DATA;
        end
    end

    // Pipeline control outputs and forwarding selects for the chosen hazard.
    always_comb begin
        pc_en     = 1'b1;
        en_ID     = 1'b1;
        en_EX     = 1'b1;
        en_MEM    = 1'b1;
        flush_ID  = 1'b0;
        flush_EX  = 1'b0;
        flush_MEM = 1'b0;
        fwd_rs    = '0;
        fwd_rt    = '0;
        hazard    = hz;
        case (hz)
            HZ_MEM: begin
                pc_en  = 1'b0;
                en_ID  = 1'b0;
                en_EX  = 1'b0;
                en_MEM = 1'b0;
            end
            HZ_CTRL: begin
                // Latch k feeds scoreboard entry k; those younger than the jump are flushed.
                flush_ID  = 1'b1;
                flush_EX  = (REDIRECT_STAGE >= 1);
                flush_MEM = (REDIRECT_STAGE >= 2);
            end
            HZ_DATA: begin
                pc_en    = 1'b0;
                en_ID    = 1'b0;
                flush_EX = 1'b1;
            end
            default: ;
        endcase
        if ((FWD_EN != 0) && (hz != HZ_DATA)) begin
            fwd_rs = youngest(hit_rs);
            fwd_rt = youngest(hit_rt);
        end
    end

    // Next scoreboard contents: hold on freeze, otherwise shift toward WB.
    always_comb begin
        nxt_v    = sb_v;
        nxt_late = sb_late;
        nxt_wsel = sb_wsel;
        if (hz != HZ_MEM) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                nxt_v[i]    = sb_v[i-1];
                nxt_wsel[i] = sb_wsel[i-1];
                nxt_late[i] = sb_late[i-1];
            end
            nxt_v[0]    = (hz == HZ_NONE) && id_valid && id_wr;
            nxt_wsel[0] = id_wsel;
            nxt_late[0] = id_late;
            if (hz == HZ_CTRL) begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i <= REDIRECT_STAGE) nxt_v[i] = 1'b0;
                end
            end
        end
    end

    // Control state: entry valid bits and the stall counter, cleared by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb_v      <= '0;
            stall_cnt <= '0;
        end else begin
            sb_v <= nxt_v;
            if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge CLK) begin
        sb_wsel <= nxt_wsel;
        sb_late <= nxt_late;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: a forwarding instance and a non-forwarding
// instance share one stimulus stream and are checked against a reference model.
module tb_hazard_scoreboard;

    localparam int D  = 3;
    localparam int RS = 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       id_valid, id_use_rs, id_use_rt, id_wr, id_late;
    logic [4:0] id_rs, id_rt, id_wsel;
    logic       redirect, dmem_req, dhit;

    logic        a_pc_en, a_en_ID, a_en_EX, a_en_MEM, a_flush_ID, a_flush_EX, a_flush_MEM;
    logic [1:0]  a_fwd_rs, a_fwd_rt, a_hazard;
    logic [15:0] a_stall_cnt;
    logic        b_pc_en, b_en_ID, b_en_EX, b_en_MEM, b_flush_ID, b_flush_EX, b_flush_MEM;
    logic [1:0]  b_fwd_rs, b_fwd_rt, b_hazard;
    logic [15:0] b_stall_cnt;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.DEPTH(D), .FWD_EN(1), .REDIRECT_STAGE(RS)) u_fwd (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wsel(id_wsel),
        .id_late(id_late), .redirect(redirect), .dmem_req(dmem_req), .dhit(dhit),
        .pc_en(a_pc_en), .en_ID(a_en_ID), .en_EX(a_en_EX), .en_MEM(a_en_MEM),
        .flush_ID(a_flush_ID), .flush_EX(a_flush_EX), .flush_MEM(a_flush_MEM),
        .fwd_rs(a_fwd_rs), .fwd_rt(a_fwd_rt), .hazard(a_hazard), .stall_cnt(a_stall_cnt)
    );

    hazard_scoreboard #(.DEPTH(D), .FWD_EN(0), .REDIRECT_STAGE(RS)) u_nofwd (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wsel(id_wsel),
        .id_late(id_late), .redirect(redirect), .dmem_req(dmem_req), .dhit(dhit),
        .pc_en(b_pc_en), .en_ID(b_en_ID), .en_EX(b_en_EX), .en_MEM(b_en_MEM),
        .flush_ID(b_flush_ID), .flush_EX(b_flush_EX), .flush_MEM(b_flush_MEM),
        .fwd_rs(b_fwd_rs), .fwd_rt(b_fwd_rt), .hazard(b_hazard), .stall_cnt(b_stall_cnt)
    );

    // Reference model: group 0 = forwarding core, group 1 = non-forwarding core.
    typedef struct packed {
        logic       v;
        logic [4:0] w;
        logic       late;
    } ent_t;

    ent_t        sb [2][D];
    int unsigned scnt [2];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit reads(int g, int i);
        ent_t e = sb[g][i];
        return e.v && (e.w != 0) && ((id_use_rs && e.w == id_rs) || (id_use_rt && e.w == id_rt));
    endfunction

    function automatic int fwd_of(int g, logic use_, logic [4:0] r);
        for (int i = 0; i < D; i++)
            if (use_ && r != 0 && sb[g][i].v && sb[g][i].w == r) return i + 1;
        return 0;
    endfunction

    function automatic int hz_of(int g);
        bit st = 0;
        if (dmem_req && !dhit) return 3;
        if (redirect) return 1;
        if (g == 0) st = reads(0, 0) && sb[0][0].late;
        else for (int i = 0; i < D - 1; i++) st = st | reads(1, i);
        return (id_valid && st) ? 2 : 0;
    endfunction

    task automatic check_group(input int g, input string nm, input logic pc,
                               input logic [2:0] en, input logic [2:0] fl,
                               input logic [1:0] fr, input logic [1:0] ft,
                               input logic [1:0] hz, input logic [15:0] sc);
        int h, en_e, fl_e, fr_e, ft_e;
        h    = hz_of(g);
        en_e = (h == 3) ? 0 : (h == 2) ? 3 : 7;
        fl_e = (h == 1) ? (4 | ((RS >= 1) ? 2 : 0) | ((RS >= 2) ? 1 : 0)) : (h == 2) ? 2 : 0;
        fr_e = (g == 0 && h != 2) ? fwd_of(g, id_use_rs, id_rs) : 0;
        ft_e = (g == 0 && h != 2) ? fwd_of(g, id_use_rt, id_rt) : 0;
        chk({nm, "_hazard"}, 32'(hz), h);
        chk({nm, "_pc_en"}, 32'(pc), (h <= 1) ? 1 : 0);
        chk({nm, "_en"}, 32'(en), en_e);
        chk({nm, "_flush"}, 32'(fl), fl_e);
        chk({nm, "_fwd_rs"}, 32'(fr), fr_e);
        chk({nm, "_fwd_rt"}, 32'(ft), ft_e);
        chk({nm, "_stall_cnt"}, 32'(sc), scnt[g]);
    endtask

    task automatic check_all();
        check_group(0, "fwd", a_pc_en, {a_en_ID, a_en_EX, a_en_MEM},
                    {a_flush_ID, a_flush_EX, a_flush_MEM}, a_fwd_rs, a_fwd_rt, a_hazard, a_stall_cnt);
        check_group(1, "nofwd", b_pc_en, {b_en_ID, b_en_EX, b_en_MEM},
                    {b_flush_ID, b_flush_EX, b_flush_MEM}, b_fwd_rs, b_fwd_rt, b_hazard, b_stall_cnt);
    endtask

    // Scoreboard moves one stage older per advancing cycle; a freeze holds it.
    task automatic commit(input int g, input int h);
        ent_t nw [D];
        if (h >= 2) scnt[g] = (scnt[g] == 65535) ? 65535 : scnt[g] + 1;
        if (h == 3) return;
        for (int i = D - 1; i >= 1; i--) nw[i] = sb[g][i-1];
        nw[0] = (h == 0) ? ent_t'({id_valid && id_wr, id_wsel, id_late}) : ent_t'(0);
        if (h == 1) for (int i = 1; i <= RS; i++) nw[i].v = 1'b0;
        for (int i = 0; i < D; i++) sb[g][i] = nw[i];
    endtask

    task automatic settle();
        #1;
    endtask

    // Called aligned to a falling edge with inputs already set.
    task automatic cycle();
        int h0, h1;
        #1;
        check_all();
        h0 = hz_of(0);
        h1 = hz_of(1);
        @(posedge CLK);
        commit(0, h0);
        commit(1, h1);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            scnt[g] = 0;
            for (int i = 0; i < D; i++) sb[g][i] = '0;
        end
        check_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic wr,
                          input logic [4:0] ws, input logic late);
        id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
        id_wr = wr;    id_wsel = ws; id_late = late;
    endtask

    task automatic set_ctl(input logic rd, input logic req, input logic hit);
        redirect = rd;  dmem_req = req;  dhit = hit;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  stalled;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0);
        #2;
        do_reset();

        // Reset state
        settle();
        chk("rst_pc_en", 32'(a_pc_en), 1);
        chk("rst_hazard", 32'(a_hazard), 0);
        chk("rst_stall_cnt", 32'(a_stall_cnt), 0);
        chk("rst_fwd_rs", 32'(a_fwd_rs), 0);
        cycle();

        // Load-use with forwarding
        set_id(1, 0, 0, 0, 0, 1, 5, 1);
        cycle();
        set_id(1, 5, 1, 0, 0, 1, 6, 0);
        settle();
        chk("lu_pc_en", 32'(a_pc_en), 0);
        chk("lu_flush_EX", 32'(a_flush_EX), 1);
        chk("lu_hazard", 32'(a_hazard), 2);
        cycle();
        settle();
        chk("lu_after_hazard", 32'(a_hazard), 0);
        chk("lu_after_fwd_rs", 32'(a_fwd_rs), 2);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // ALU chain
        set_id(1, 0, 0, 0, 0, 1, 3, 0);
        cycle();
        set_id(1, 0, 0, 3, 1, 1, 4, 0);
        settle();
        chk("alu_hazard", 32'(a_hazard), 0);
        chk("alu_fwd_rt1", 32'(a_fwd_rt), 1);
        cycle();
        set_id(1, 3, 1, 0, 0, 0, 0, 0);
        settle();
        chk("alu_fwd_rs2", 32'(a_fwd_rs), 2);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // No forwarding: writer of $7 then reader of $7
        do_reset();
        settle();
        chk("nf_cnt0", 32'(b_stall_cnt), 0);
        set_id(1, 0, 0, 0, 0, 1, 7, 0);
        cycle();
        set_id(1, 7, 1, 0, 0, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            stalled = (b_hazard == 2'd2);
            if (stalled) n++;
            cycle();
            if (!stalled) break;
        end
        chk("nf_stall_cycles", n, 2);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("nf_cnt2", 32'(b_stall_cnt), 2);
        cycle();

        // Redirect at entry 1
        set_id(1, 0, 0, 0, 0, 1, 8, 0);
        cycle();
        set_id(1, 0, 0, 0, 0, 1, 9, 0);
        cycle();
        set_id(1, 0, 0, 0, 0, 1, 10, 0);
        set_ctl(1, 0, 0);
        settle();
        chk("rd_flush_ID", 32'(a_flush_ID), 1);
        chk("rd_flush_EX", 32'(a_flush_EX), 1);
        chk("rd_flush_MEM", 32'(a_flush_MEM), 0);
        chk("rd_hazard", 32'(a_hazard), 1);
        cycle();
        set_ctl(0, 0, 0);
        set_id(1, 9, 1, 8, 1, 0, 0, 0);
        settle();
        chk("rd_cleared_fwd", 32'(a_fwd_rs), 0);
        chk("rd_kept_fwd", 32'(a_fwd_rt), 3);
        cycle();

        // Freeze with a pending redirect
        set_id(1, 0, 0, 0, 0, 1, 11, 0);
        cycle();
        set_id(1, 11, 1, 0, 0, 0, 0, 0);
        set_ctl(1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("fz_hazard", 32'(a_hazard), 3);
            chk("fz_fwd_hold", 32'(a_fwd_rs), 1);
            cycle();
        end
        set_ctl(1, 1, 1);
        settle();
        chk("fz_dhit_hazard", 32'(a_hazard), 1);
        chk("fz_dhit_flush_EX", 32'(a_flush_EX), 1);
        cycle();
        set_ctl(0, 0, 0);

        // Register 0 never matches
        set_id(1, 0, 0, 0, 0, 1, 0, 1);
        cycle();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        settle();
        chk("r0_hazard", 32'(a_hazard), 0);
        chk("r0_fwd_rs", 32'(a_fwd_rs), 0);
        chk("r0_nofwd_hazard", 32'(b_hazard), 0);
        cycle();

        // Reset during a load-use stall
        set_id(1, 0, 0, 0, 0, 1, 5, 1);
        cycle();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        settle();
        chk("rs_stall", 32'(a_hazard), 2);
        do_reset();
        settle();
        chk("rs_pc_en", 32'(a_pc_en), 1);
        chk("rs_hazard", 32'(a_hazard), 0);
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            set_id(1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 3) == 0));
            set_ctl(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
